// File: rtl/multiword_add_sequencer_if.sv
// Request/result bundle between operand producer, sequencer and result consumer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface multiword_add_sequencer_if #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4
);
    localparam int OP_W = WORD_W * NWORDS;

    logic            in_valid;
    logic            in_ready;
    logic            op_sub;
    logic            cin;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] sum;
    logic            cout;
    logic            ovf;

    // Producer/consumer side.
    modport master (
        output in_valid, op_sub, cin, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Sequencer side.
    modport slave (
        input  in_valid, op_sub, cin, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Word-serial multi-precision add/sub reusing one WORD_W-bit prefix adder, LS word first.
// Latency: out_valid rises NWORDS edges after the accept edge; one op per NWORDS+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.

// Kogge-Stone style parallel-prefix adder slice.
// Latency: combinational.
// Backpressure: none.
module prefix_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    localparam int LV = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0] p0;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;

    // Prefix tree: carry-in folded into bit 0 generate, so g[i] ends up as carry into bit i+1.
    always_comb begin
        p0   = a ^ b;
        g    = a & b;
        g[0] = g[0] | (p0[0] & cin);
        p    = p0;
        gn   = g;
        pn   = p;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[(i >= (1 << l)) ? i - (1 << l) : i]);
                    pn[i] = p[i] & p[(i >= (1 << l)) ? i - (1 << l) : i];
                end
            end
            g = gn;
            p = pn;
        end
        s    = p0 ^ {g[W-2:0], cin};
        cout = g[W-1];
    end
endmodule

module multiword_add_sequencer #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multiword_add_sequencer_if.slave  bus
);
    localparam int OP_W  = WORD_W * NWORDS;
    localparam int IDX_W = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic [OP_W-1:0]   sum_reg;
    logic              carry_reg;
    logic              cout_reg;
    logic              ovf_reg;
    logic              out_valid_reg;
    logic              accept;

    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic [WORD_W-1:0] s_word;
    logic              c_word;

    assign accept = bus.in_valid && (state == IDLE);
    assign a_word = a_reg[idx*WORD_W +: WORD_W];
    assign b_word = b_reg[idx*WORD_W +: WORD_W];

    prefix_adder #(.W(WORD_W)) u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_reg),
        .s    (s_word),
        .cout (c_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept -> one word per cycle -> hold result until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, per-word sum/carry update, final flags and result valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtract runs as a + ~b + ~cin so cout=1 means "no borrow".
                        a_reg     <= bus.a;
                        b_reg     <= bus.op_sub ? ~bus.b : bus.b;
                        carry_reg <= bus.cin ^ bus.op_sub;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx*WORD_W +: WORD_W] <= s_word;
                    carry_reg                     <= c_word;
                    if (idx == LAST) begin
                        cout_reg      <= c_word;
                        ovf_reg       <= (a_reg[OP_W-1] == b_reg[OP_W-1]) &&
                                         (s_word[WORD_W-1] != a_reg[OP_W-1]);
                        out_valid_reg <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_reg <= 1'b0;
                end
                default: out_valid_reg <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
endmodule
